// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit placed in front of a word-wide data_memory.
//   Takes one byte-addressed request at a time, issues word-only memory
//   accesses, extracts and extends sub-word load lanes, and performs a
//   read-modify-write for byte/half stores. Results go to write-back over a
//   valid/ready response channel.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined     : misaligned half/word requests skip memory and respond
//                   one cycle after accept with o_resp_err=1, data 0.
//     not defined : o_resp_err is 0; misaligned low address bits are ignored.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid / o_req_ready    request handshake (ready only when idle)
//   i_req_write                  1 store, 0 load
//   i_req_size                   00 byte, 01 half, 1x word
//   i_req_unsigned               zero-extend loads when 1
//   i_req_addr                   byte address
//   i_req_wdata                  store data, sub-word data in low bits
//   i_req_rd                     destination tag echoed on the response
//   o_resp_valid / i_resp_ready  response handshake
//   o_resp_data                  extended load data, 0 for stores
//   o_resp_rd                    tag of the request
//   o_resp_err                   misaligned-access flag
//   o_mem_addr                   word index to memory
//   o_mem_we / o_mem_re          write / read enables (one cycle each)
//   o_mem_size                   constant 0 (word access)
//   o_mem_wdata                  full word to write
//   i_mem_rdata                  registered read data, valid cycle after re
module mem_access_unit #(
   parameter int ADDR_LENGTH = 32,
   parameter int DATA_LENGTH = 32,
   parameter int REG_ADDR    = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic                   i_req_write,
   input  logic [1:0]             i_req_size,
   input  logic                   i_req_unsigned,
   input  logic [ADDR_LENGTH-1:0] i_req_addr,
   input  logic [DATA_LENGTH-1:0] i_req_wdata,
   input  logic [REG_ADDR-1:0]    i_req_rd,
   output logic                   o_resp_valid,
   input  logic                   i_resp_ready,
   output logic [DATA_LENGTH-1:0] o_resp_data,
   output logic [REG_ADDR-1:0]    o_resp_rd,
   output logic                   o_resp_err,
   output logic [ADDR_LENGTH-1:0] o_mem_addr,
   output logic                   o_mem_we,
   output logic                   o_mem_re,
   output logic [5:0]             o_mem_size,
   output logic [DATA_LENGTH-1:0] o_mem_wdata,
   input  logic [DATA_LENGTH-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t state, state_next;

   logic                   write_q;
   logic [1:0]             size_q;
   logic                   uns_q;
   logic [ADDR_LENGTH-1:0] addr_q;
   logic [REG_ADDR-1:0]    rd_q;
   // Holds the store data from accept until CAP, then the merged word for WR.
   logic [DATA_LENGTH-1:0] word_q;
   logic [DATA_LENGTH-1:0] resp_data_q;

   logic                   fire;
   logic                   trap;
   logic [7:0]             lane8;
   logic [15:0]            lane16;
   logic [DATA_LENGTH-1:0] load_ext;
   logic [DATA_LENGTH-1:0] merged;

   assign fire = (state == IDLE) && i_req_valid;

`ifdef MISALIGN_TRAP_EN
   logic err_q;
   assign trap = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                 (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
   assign o_resp_err = err_q;
`else
   assign trap = 1'b0;
   assign o_resp_err = 1'b0;
`endif

   // Load lane extraction and extension from the freshly registered word.
   always_comb begin
      lane8  = '0;
      lane16 = '0;
      case (addr_q[1:0])
         2'd0: lane8 = i_mem_rdata[7:0];
         2'd1: lane8 = i_mem_rdata[15:8];
         2'd2: lane8 = i_mem_rdata[23:16];
         default: lane8 = i_mem_rdata[31:24];
      endcase
      lane16 = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & lane8[7]}}, lane8};
         2'b01:   load_ext = {{16{~uns_q & lane16[15]}}, lane16};
         default: load_ext = i_mem_rdata;
      endcase
   end

   // Sub-word store merge: only the addressed lane takes new data.
   always_comb begin
      merged = i_mem_rdata;
      if (size_q == 2'b00) begin
         case (addr_q[1:0])
            2'd0: merged[7:0]   = word_q[7:0];
            2'd1: merged[15:8]  = word_q[7:0];
            2'd2: merged[23:16] = word_q[7:0];
            default: merged[31:24] = word_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = word_q[15:0];
      end else begin
         merged[15:0] = word_q[15:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fire) begin
               if (trap)
                  state_next = RESP;
               else if (i_req_write && i_req_size[1])
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:   state_next = CAP;
         CAP:  state_next = write_q ? WR : RESP;
         WR:   state_next = RESP;
         RESP: if (i_resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         write_q     <= 1'b0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         rd_q        <= '0;
         word_q      <= '0;
         resp_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
         err_q       <= 1'b0;
`endif
      end else begin
         if (fire) begin
            write_q     <= i_req_write;
            size_q      <= i_req_size;
            uns_q       <= i_req_unsigned;
            addr_q      <= i_req_addr;
            rd_q        <= i_req_rd;
            word_q      <= i_req_wdata;
            resp_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= trap;
`endif
         end
         if (state == CAP) begin
            if (write_q)
               word_q <= merged;
            else
               resp_data_q <= load_ext;
         end
      end
   end

   assign o_req_ready  = (state == IDLE) && !i_rst;
   assign o_resp_valid = (state == RESP);
   assign o_resp_data  = resp_data_q;
   assign o_resp_rd    = rd_q;
   assign o_mem_addr   = {2'b00, addr_q[ADDR_LENGTH-1:2]};
   assign o_mem_re     = (state == RD);
   assign o_mem_we     = (state == WR);
   assign o_mem_size   = '0;
   assign o_mem_wdata  = (state == WR) ? word_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [4:0]  i_req_rd;
   logic        o_resp_valid;
   logic        i_resp_ready;
   logic [31:0] o_resp_data;
   logic [4:0]  o_resp_rd;
   logic        o_resp_err;
   logic [31:0] o_mem_addr;
   logic        o_mem_we;
   logic        o_mem_re;
   logic [5:0]  o_mem_size;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   mem_access_unit #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .REG_ADDR(5)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_write(i_req_write), .i_req_size(i_req_size),
      .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata), .i_req_rd(i_req_rd),
      .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_resp_data(o_resp_data), .o_resp_rd(o_resp_rd), .o_resp_err(o_resp_err),
      .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
      .o_mem_size(o_mem_size), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      bit          abort;
      logic [31:0] data;
      logic [4:0]  rd;
      bit          err;
      int          lat;
      int          nre;
      int          nwe;
      logic [31:0] widx;
      logic [31:0] wword;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem[64];      // stand-in for data_memory
   logic [31:0] ref_mem[64];  // reference view of memory contents
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   bit          force_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned a,
                                            input int unsigned sz, input bit uns);
      int unsigned wu = w;
      int unsigned v;
      if (sz == 0) begin
         v = (wu >> (8 * (a % 4))) % 256;
         if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = (wu >> (16 * ((a / 2) % 2))) % 65536;
         if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
         v = wu;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input int unsigned a,
                                             input int unsigned sz, input logic [31:0] d);
      int unsigned wu = w;
      int unsigned du = d;
      int unsigned sh;
      int unsigned mask;
      if (sz == 0) begin
         sh = 8 * (a % 4);
         mask = 255 << sh;
         return (wu & ~mask) | ((du % 256) << sh);
      end else if (sz == 1) begin
         sh = 16 * ((a / 2) % 2);
         mask = 65535 << sh;
         return (wu & ~mask) | ((du % 65536) << sh);
      end
      return du;
   endfunction

   // Clock, cycle counter, memory stand-in (writes on negedge, registered reads).
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (o_mem_we) mem[o_mem_addr[5:0]] = o_mem_wdata;
   end

   always @(posedge clk) begin
      if (o_mem_re) i_mem_rdata <= mem[o_mem_addr[5:0]];
   end

   // Response-ready driver: random backpressure, or a forced 5-cycle stall.
   initial begin
      int stall_seen;
      stall_seen = 0;
      i_resp_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         if (force_stall) begin
            if (o_resp_valid) begin
               stall_seen++;
               i_resp_ready = (stall_seen > 5);
            end else begin
               stall_seen = 0;
               i_resp_ready = 0;
            end
         end else begin
            stall_seen = 0;
            i_resp_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: pops the expected response at accept, checks bus activity,
   // latency, stability under backpressure, and the response on handshake.
   initial begin
      exp_t        cur;
      bit          active;
      bit          seen_valid;
      int          acc_cyc;
      int          nre;
      int          nwe;
      logic [31:0] hold_data;
      logic [4:0]  hold_rd;
      logic        hold_err;
      active = 0;
      seen_valid = 0;
      acc_cyc = 0;
      nre = 0;
      nwe = 0;
      hold_data = '0;
      hold_rd = '0;
      hold_err = 0;
      forever begin
         @(negedge clk);
         if (i_rst) begin
            check("rst_we", {31'b0, o_mem_we}, 32'd0);
            if (active && cur.abort) check("abort_no_we", nwe, 0);
            active = 0;
         end else begin
            if (o_mem_we && o_mem_re) check("we_re_exclusive", 32'd1, 32'd0);
            if (i_req_valid && o_req_ready) begin
               if (exp_q.size() == 0) begin
                  check("accept_unexpected", 32'd1, 32'd0);
               end else begin
                  cur = exp_q.pop_front();
                  active = 1;
                  seen_valid = 0;
                  acc_cyc = cyc;
                  nre = 0;
                  nwe = 0;
               end
            end
            if (o_mem_re || o_mem_we) begin
               if (!active) begin
                  check("stray_mem_access", 32'd1, 32'd0);
               end else begin
                  check("mem_addr", o_mem_addr, cur.widx);
                  if (o_mem_re) nre++;
                  if (o_mem_we) begin
                     nwe++;
                     check("mem_wdata", o_mem_wdata, cur.wword);
                  end
               end
            end
            if (o_resp_valid) begin
               if (!active) begin
                  check("stray_resp", 32'd1, 32'd0);
               end else begin
                  check("ready_low_in_resp", {31'b0, o_req_ready}, 32'd0);
                  if (!seen_valid) begin
                     check("latency", cyc - acc_cyc, cur.lat);
                     hold_data = o_resp_data;
                     hold_rd = o_resp_rd;
                     hold_err = o_resp_err;
                     seen_valid = 1;
                  end else begin
                     check("hold_data", o_resp_data, hold_data);
                     check("hold_rd", {27'b0, o_resp_rd}, {27'b0, hold_rd});
                     check("hold_err", {31'b0, o_resp_err}, {31'b0, hold_err});
                  end
                  if (i_resp_ready) begin
                     check("resp_data", o_resp_data, cur.data);
                     check("resp_rd", {27'b0, o_resp_rd}, {27'b0, cur.rd});
                     check("resp_err", {31'b0, o_resp_err}, {31'b0, cur.err});
                     check("re_count", nre, cur.nre);
                     check("we_count", nwe, cur.nwe);
                     active = 0;
                     done_cnt++;
                  end
               end
            end
         end
      end
   end

   task automatic wait_accept();
      bit ok;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (o_req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no ready expected ready within 50 cycles");
         finish_run();
      end
      @(posedge clk);
      #1;
      i_req_valid = 0;
   endtask

   task automatic do_req(input bit wr, input int unsigned sz, input bit uns,
                         input int unsigned a, input logic [31:0] d, input logic [4:0] rd);
      exp_t e;
      int unsigned wi;
      bit mis;
      int start;
      bit ok;
      wi = a / 4;
      mis = TRAP && ((sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0));
      e.abort = 0;
      e.rd = rd;
      e.widx = wi;
      e.err = mis;
      e.wword = '0;
      e.data = '0;
      if (mis) begin
         e.lat = 1; e.nre = 0; e.nwe = 0;
      end else if (wr) begin
         e.wword = ref_store(ref_mem[wi], a, sz, d);
         ref_mem[wi] = e.wword;
         if (sz >= 2) begin e.lat = 2; e.nre = 0; e.nwe = 1; end
         else begin e.lat = 4; e.nre = 1; e.nwe = 1; end
      end else begin
         e.data = ref_load(ref_mem[wi], a, sz, uns);
         e.lat = 3; e.nre = 1; e.nwe = 0;
      end
      exp_q.push_back(e);
      start = done_cnt;
      @(posedge clk);
      #1;
      i_req_valid = 1;
      i_req_write = wr;
      i_req_size = sz[1:0];
      i_req_unsigned = uns;
      i_req_addr = a;
      i_req_wdata = d;
      i_req_rd = rd;
      wait_accept();
      ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done_cnt != start) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: got no response expected response within 60 cycles");
         finish_run();
      end
   endtask

   initial begin
      #2_000_000;
      checks++;
      errors++;
      $display("FAIL watchdog: got no end expected end of run");
      finish_run();
   end

   initial begin
      exp_t e;
      logic [31:0] v;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      i_rst = 1;
      i_req_valid = 0;
      i_req_write = 0;
      i_req_size = 0;
      i_req_unsigned = 0;
      i_req_addr = 0;
      i_req_wdata = 0;
      i_req_rd = 0;
      i_mem_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'b0, o_req_ready}, 32'd0);
      check("rst_valid", {31'b0, o_resp_valid}, 32'd0);
      check("rst_err", {31'b0, o_resp_err}, 32'd0);
      check("rst_re", {31'b0, o_mem_re}, 32'd0);
      check("rst_data", o_resp_data, 32'd0);
      check("rst_rd", {27'b0, o_resp_rd}, 32'd0);
      check("rst_addr", o_mem_addr, 32'd0);
      check("rst_wdata", o_mem_wdata, 32'd0);
      check("rst_size", {26'b0, o_mem_size}, 32'd0);
      @(posedge clk);
      #1;
      i_rst = 0;
      @(negedge clk);
      check("ready_after_rst", {31'b0, o_req_ready}, 32'd1);

      // Word store then load back.
      do_req(1, 2, 0, 32'h10, 32'hDEADBEEF, 5'd1);
      do_req(0, 2, 0, 32'h10, 32'h0, 5'd2);
      // Byte / half extension.
      do_req(1, 2, 0, 32'h20, 32'h80FF7F01, 5'd3);
      do_req(0, 0, 0, 32'h23, 32'h0, 5'd4);
      do_req(0, 0, 1, 32'h23, 32'h0, 5'd5);
      do_req(0, 1, 0, 32'h22, 32'h0, 5'd6);
      do_req(0, 1, 1, 32'h22, 32'h0, 5'd7);
      do_req(0, 0, 0, 32'h21, 32'h0, 5'd8);
      // Half store read-modify-write.
      do_req(1, 2, 0, 32'h10, 32'h11223344, 5'd9);
      do_req(1, 1, 0, 32'h12, 32'hFFFFABCD, 5'd10);
      do_req(0, 2, 0, 32'h10, 32'h0, 5'd11);
      // Backpressure hold.
      force_stall = 1;
      do_req(0, 2, 0, 32'h20, 32'h0, 5'd12);
      force_stall = 0;
      // Reset pulsed during the read phase of a byte store.
      do_req(1, 2, 0, 32'h30, 32'h5A5AA5A5, 5'd13);
      e.abort = 1; e.data = '0; e.rd = '0; e.err = 0; e.lat = 0;
      e.nre = 1; e.nwe = 0; e.widx = 32'd12; e.wword = '0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      i_req_valid = 1;
      i_req_write = 1;
      i_req_size = 2'b00;
      i_req_addr = 32'h31;
      i_req_wdata = 32'h000000FF;
      i_req_rd = 5'd14;
      wait_accept();
      check("abort_in_rd", {31'b0, o_mem_re}, 32'd1);
      i_rst = 1;
      #1;
      check("abort_re", {31'b0, o_mem_re}, 32'd0);
      check("abort_we", {31'b0, o_mem_we}, 32'd0);
      check("abort_valid", {31'b0, o_resp_valid}, 32'd0);
      check("abort_ready", {31'b0, o_req_ready}, 32'd0);
      check("abort_addr", o_mem_addr, 32'd0);
      check("abort_rd", {27'b0, o_resp_rd}, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      i_rst = 0;
      @(negedge clk);
      check("abort_ready_after", {31'b0, o_req_ready}, 32'd1);
      do_req(0, 2, 0, 32'h30, 32'h0, 5'd15);
      // Misaligned half load and word accesses.
      do_req(0, 1, 0, 32'h21, 32'h0, 5'd16);
      do_req(0, 2, 0, 32'h22, 32'h0, 5'd17);
      do_req(1, 1, 0, 32'h11, 32'h00001234, 5'd18);
      do_req(0, 2, 0, 32'h10, 32'h0, 5'd19);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         do_req($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 255), $urandom, $urandom_range(0, 31));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      // Final sweep of every word.
      for (int w = 0; w < 64; w++) begin
         do_req(0, 2, 0, w * 4, 32'h0, w[4:0]);
      end
      repeat (3) @(posedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      finish_run();
   end

endmodule
